// File: rtl/amba3_apb_arbiter.sv
// Shares one AMBA3 APB master port between NUM_REQ req/ack requesters with round-robin
// arbitration. Runs SETUP/ACCESS, returns read data and error, optional PREADY watchdog.
module amba3_apb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int TIMEOUT   = 0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           ack,
    output logic [DATA_SIZE-1:0]         rdata,
    output logic                         slverr,
    output logic                         timeout,
    output logic [ADDR_SIZE-1:0]         paddr,
    output logic                         psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [DATA_SIZE-1:0]         pwdata,
    input  logic [DATA_SIZE-1:0]         prdata,
    input  logic                         pready,
    input  logic                         pslverr
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);
    localparam logic [CW-1:0] WD_LAST  = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [GW:0]   NUM_W    = (GW+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         gnt_q, gnt_d;
    logic [CW-1:0]         wd_cnt_q, wd_cnt_d;
    logic [ADDR_SIZE-1:0]  paddr_q, paddr_d;
    logic [DATA_SIZE-1:0]  pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [DATA_SIZE-1:0]  rdata_q, rdata_d;
    logic                  slverr_q, slverr_d;
    logic                  timeout_q, timeout_d;

    logic [ADDR_SIZE-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_SIZE-1:0]  wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    elig;
    logic                  found;
    logic [GW-1:0]         pick;
    logic [GW:0]           idx;
    logic [GW-1:0]         ptr_next;
    logic                  complete;
    logic                  abort;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_SIZE +: ADDR_SIZE];
            assign wdata_arr[gi] = req_wdata[gi*DATA_SIZE +: DATA_SIZE];
        end
    endgenerate

    // A requester being acked this cycle may still hold req; that level is not a new command yet.
    assign elig = req & ~ack_q;

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (GW+1)'(k);
            if (idx >= NUM_W) begin
                idx = idx - NUM_W;
            end
            if (!found && elig[idx[GW-1:0]]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
    end

    assign ptr_next = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        wd_cnt_d  = wd_cnt_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        slverr_d  = 1'b0;
        timeout_d = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d     = pick;
                    paddr_d   = addr_arr[pick];
                    pwrite_d  = req_write[pick];
                    pwdata_d  = wdata_arr[pick];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    wd_cnt_d  = '0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    complete = 1'b1;
                end else if (TIMEOUT > 0) begin
                    // The count reaches TIMEOUT on the same edge that aborts, so ACCESS lasts TIMEOUT cycles.
                    wd_cnt_d = wd_cnt_q + 1'b1;
                    if (wd_cnt_q == WD_LAST) begin
                        complete = 1'b1;
                        abort    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (complete) begin
            ack_d[gnt_q] = 1'b1;
            rdata_d      = (pwrite_q || abort) ? '0 : prdata;
            slverr_d     = abort ? 1'b1 : pslverr;
            timeout_d    = abort;
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            ptr_d        = ptr_next;
            state_d      = S_IDLE;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            wd_cnt_q  <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            wd_cnt_q  <= wd_cnt_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            timeout_q <= timeout_d;
        end
    end

    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign slverr  = slverr_q;
    assign timeout = timeout_q;
    assign paddr   = paddr_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_amba3_apb_arbiter.sv
// Bench for amba3_apb_arbiter: directed vector table, hand-written corner sequences, and random
// traffic checked by a transfer-level round-robin/APB reference model.
module tb_amba3_apb_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            pclk = 1'b0;
    logic            preset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            slverr, timeout;
    logic [AW-1:0]   paddr;
    logic            psel, penable, pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata = '0;
    logic            pready = 1'b0;
    logic            pslverr = 1'b0;

    logic [AW-1:0]   c_addr  [N];
    logic [DW-1:0]   c_wdata [N];

    always #5 pclk = ~pclk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = c_addr[i];
            req_wdata[i*DW +: DW] = c_wdata[i];
        end
    end

    amba3_apb_arbiter #(.NUM_REQ(N), .ADDR_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
        .slverr(slverr), .timeout(timeout), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // reference model state
    int           ptr_m = 0;
    int           g_m = 0;
    int           n_acc = 0;
    bit           busy = 0;
    bit           done_next = 0;
    logic [N-1:0] ack_prev = '0;
    logic [N-1:0] hold_ack = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic         exp_err = 1'b0;
    logic         exp_to = 1'b0;
    // slave behaviour for the transfer in flight
    bit           sl_rand = 0;
    int           sl_wait = 0;
    logic [DW-1:0] sl_rdata = '0;
    logic         sl_err = 1'b0;
    int           cfg_wait = 0;
    logic [DW-1:0] cfg_rdata = '0;
    logic         cfg_err = 1'b0;
    // observation logs
    int           grant_q[$];
    int           grant_cyc_q[$];
    int           ack_cyc_q[$];
    logic [DW-1:0] last_rdata = '0;
    logic         last_err = 1'b0;
    logic         last_to = 1'b0;

    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] rd;
        logic        err;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_acc;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 'h%0h required 'h%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("[TB] FAIL %s: bound expired, got no event required event (cycle %0d)", nm, cyc);
    endtask

    task automatic new_cmd(input int i);
        c_addr[i]    = $urandom;
        c_wdata[i]   = $urandom;
        req_write[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_junk();
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
    endtask

    // One clock: observe at the falling edge, compare with the model, then set slave inputs.
    task automatic step();
        logic [N-1:0] elig;
        logic [N-1:0] exp_ack;
        int g;
        @(negedge pclk);
        cyc++;
        exp_ack = '0;
        if (busy && done_next) begin
            exp_ack[g_m] = 1'b1;
            chk("ack_onehot", 64'(ack), 64'(exp_ack));
            chk("rdata", 64'(rdata), 64'(exp_rdata));
            chk("slverr", 64'(slverr), 64'(exp_err));
            chk("timeout", 64'(timeout), 64'(exp_to));
            chk("psel_penable_end", 64'({psel, penable}), 64'(0));
            $display("[TB] xfer req%0d %s addr=%08h rdata=%08h slverr=%0b timeout=%0b access=%0d",
                     g_m, req_write[g_m] ? "WR" : "RD", c_addr[g_m], rdata, slverr, timeout, n_acc);
            last_rdata = rdata;
            last_err   = slverr;
            last_to    = timeout;
            ack_cyc_q.push_back(cyc);
            ptr_m     = (g_m + 1) % N;
            busy      = 0;
            done_next = 0;
            if (hold_ack[g_m]) new_cmd(g_m);
            else req[g_m] = 1'b0;
            drive_junk();
        end else begin
            chk("no_completion", 64'({ack, slverr, timeout}), 64'(0));
            if (!busy) begin
                elig = req & ~ack_prev;
                if (elig != '0) begin
                    g = ptr_m;
                    while (!elig[g]) g = (g + 1) % N;
                    chk("setup_phase", 64'({psel, penable}), 64'(2'b10));
                    chk("setup_paddr", 64'(paddr), 64'(c_addr[g]));
                    chk("setup_pwrite", 64'(pwrite), 64'(req_write[g]));
                    chk("setup_pwdata", 64'(pwdata), 64'(c_wdata[g]));
                    g_m   = g;
                    busy  = 1;
                    n_acc = 0;
                    grant_q.push_back(g);
                    grant_cyc_q.push_back(cyc);
                    if (sl_rand) begin
                        sl_wait  = ($urandom_range(0, 7) == 0) ? 30 : int'($urandom_range(0, 3));
                        sl_rdata = $urandom;
                        sl_err   = ($urandom_range(0, 3) == 0);
                    end else begin
                        sl_wait  = cfg_wait;
                        sl_rdata = cfg_rdata;
                        sl_err   = cfg_err;
                    end
                end else begin
                    chk("idle_psel", 64'({psel, penable}), 64'(0));
                end
                drive_junk();
            end else begin
                chk("access_phase", 64'({psel, penable}), 64'(2'b11));
                chk("access_paddr", 64'(paddr), 64'(c_addr[g_m]));
                n_acc++;
                pready  = 1'b0;
                pslverr = 1'($urandom_range(0, 1));
                prdata  = $urandom;
                if (n_acc == sl_wait + 1 && n_acc <= TO) begin
                    pready    = 1'b1;
                    pslverr   = sl_err;
                    prdata    = sl_rdata;
                    done_next = 1;
                    exp_to    = 1'b0;
                    exp_err   = sl_err;
                    exp_rdata = req_write[g_m] ? '0 : sl_rdata;
                end else if (n_acc == TO) begin
                    done_next = 1;
                    exp_to    = 1'b1;
                    exp_err   = 1'b1;
                    exp_rdata = '0;
                end
            end
        end
        ack_prev = ack;
    endtask

    task automatic drain(input string nm);
        int k;
        for (k = 0; k < 200 && (busy || req != '0); k++) step();
        if (busy || req != '0) fail_now(nm);
    endtask

    // Call just after a falling edge; asserts reset mid-cycle, holds it over one rising edge.
    task automatic do_reset();
        #2 preset = 1'b1;
        #1;
        chk("rst_async_psel", 64'({psel, penable}), 64'(0));
        chk("rst_async_ack", 64'(ack), 64'(0));
        busy      = 0;
        done_next = 0;
        ptr_m     = 0;
        ack_prev  = '0;
        @(negedge pclk);
        chk("rst_hold_outputs", 64'({ack, slverr, timeout, psel, penable, pwrite}), 64'(0));
        chk("rst_hold_data", 64'(paddr | pwdata | rdata), 64'(0));
        preset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int vn);
        int t0, g0, n0, k;
        cfg_wait  = v.wait_n;
        cfg_rdata = v.rd;
        cfg_err   = v.err;
        sl_rand   = 0;
        c_addr[v.idx]    = v.addr;
        c_wdata[v.idx]   = v.wdata;
        req_write[v.idx] = v.wr;
        req[v.idx]       = 1'b1;
        t0 = cyc;
        g0 = grant_q.size();
        n0 = ack_cyc_q.size();
        for (k = 0; k < 40 && ack_cyc_q.size() == n0; k++) step();
        if (ack_cyc_q.size() == n0 || grant_q.size() == g0) begin
            fail_now($sformatf("vec%0d_ack", vn));
        end else begin
            chk($sformatf("vec%0d_grant", vn), 64'(grant_q[g0]), 64'(v.idx));
            chk($sformatf("vec%0d_psel_latency", vn), 64'(grant_cyc_q[g0] - t0), 64'(1));
            chk($sformatf("vec%0d_access_len", vn), 64'(ack_cyc_q[n0] - grant_cyc_q[g0] - 1), 64'(v.e_acc));
            chk($sformatf("vec%0d_ack_latency", vn), 64'(ack_cyc_q[n0] - t0), 64'(2 + v.e_acc));
            chk($sformatf("vec%0d_rdata", vn), 64'(last_rdata), 64'(v.e_rdata));
            chk($sformatf("vec%0d_slverr", vn), 64'(last_err), 64'(v.e_err));
            chk($sformatf("vec%0d_timeout", vn), 64'(last_to), 64'(v.e_to));
        end
        step();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_time_limit: got no finish required finish");
        $fatal(1, "time limit");
    end

    initial begin
        int g0, n0, k;
        for (int i = 0; i < N; i++) begin
            c_addr[i]  = '0;
            c_wdata[i] = '0;
        end
        //             idx wr    addr          wdata         wait rd            err   e_rdata       e_err e_to  acc
        vecs[0] = '{1, 1'b1, 32'h0000_0040, 32'h8000_3333, 0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[1] = '{0, 1'b0, 32'h0000_0140, 32'h0,         3,  32'h0000_001C, 1'b0, 32'h0000_001C, 1'b0, 1'b0, 4};
        vecs[2] = '{2, 1'b0, 32'h0000_0200, 32'h0,         1,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2};
        vecs[3] = '{3, 1'b1, 32'h0000_0300, 32'h1234_5678, 0,  32'hFFFF_FFFF, 1'b1, 32'h0,        1'b1, 1'b0, 1};
        vecs[4] = '{2, 1'b0, 32'h0000_0044, 32'h0,         50, 32'hA5A5_A5A5, 1'b0, 32'h0,        1'b1, 1'b1, 8};
        vecs[5] = '{1, 1'b0, 32'h0000_0048, 32'h0,         7,  32'h0000_55AA, 1'b0, 32'h0000_55AA, 1'b0, 1'b0, 8};
        vecs[6] = '{0, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 30, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 8};

        repeat (2) @(negedge pclk);
        chk("reset_outputs", 64'({ack, slverr, timeout, psel, penable, pwrite}), 64'(0));
        chk("reset_data", 64'(paddr | pwdata | rdata), 64'(0));
        preset = 1'b0;

        for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

        // fairness: all four held continuously from reset
        do_reset();
        cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = 32'h0BAD_0001; sl_rand = 0;
        hold_ack = '1;
        for (int i = 0; i < N; i++) new_cmd(i);
        req = '1;
        g0 = grant_q.size();
        for (k = 0; k < 60 && grant_q.size() < g0 + 8; k++) step();
        if (grant_q.size() < g0 + 8) begin
            fail_now("fair_grants");
        end else begin
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("fair_order_%0d", j), 64'(grant_q[g0 + j]), 64'(j % N));
                if (j > 0) chk($sformatf("fair_period_%0d", j),
                               64'(grant_cyc_q[g0 + j] - grant_cyc_q[g0 + j - 1]), 64'(3));
            end
        end
        hold_ack = '0;
        drain("fair_drain");

        // wrap and mask: ptr at 3, req3 re-issued in its ack cycle, 0 and 2 pending
        do_reset();
        new_cmd(2); req[2] = 1'b1;
        drain("wrap_prep");
        cfg_wait = 2;
        hold_ack[3] = 1'b1;
        new_cmd(3); req[3] = 1'b1;
        g0 = grant_q.size();
        for (k = 0; k < 10 && !busy; k++) step();
        new_cmd(0); new_cmd(2);
        req[0] = 1'b1; req[2] = 1'b1;
        n0 = ack_cyc_q.size();
        for (k = 0; k < 20 && ack_cyc_q.size() == n0; k++) step();
        hold_ack = '0;
        drain("wrap_drain");
        chk("wrap_count", 64'(grant_q.size() - g0), 64'(4));
        if (grant_q.size() >= g0 + 4) begin
            chk("wrap_g0", 64'(grant_q[g0]), 64'(3));
            chk("wrap_g1", 64'(grant_q[g0 + 1]), 64'(0));
            chk("wrap_g2", 64'(grant_q[g0 + 2]), 64'(2));
            chk("wrap_g3", 64'(grant_q[g0 + 3]), 64'(3));
        end

        // reset during an ACCESS wait state: aborted transfer not acked, re-arbitration from 0
        cfg_wait = 0;
        new_cmd(1); req[1] = 1'b1;
        drain("midrst_prep");
        cfg_wait = 50;
        new_cmd(3); req[3] = 1'b1;
        for (k = 0; k < 10 && !(busy && n_acc >= 2); k++) step();
        chk("midrst_in_access", 64'({psel, penable}), 64'(2'b11));
        new_cmd(1); req[1] = 1'b1;
        n0 = ack_cyc_q.size();
        do_reset();
        cfg_wait = 0;
        g0 = grant_q.size();
        drain("midrst_drain");
        chk("midrst_count", 64'(grant_q.size() - g0), 64'(2));
        if (grant_q.size() >= g0 + 2) begin
            chk("midrst_first", 64'(grant_q[g0]), 64'(1));
            chk("midrst_second", 64'(grant_q[g0 + 1]), 64'(3));
        end
        chk("midrst_acks", 64'(ack_cyc_q.size() - n0), 64'(2));

        // random traffic against the model
        sl_rand = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 4) == 0) begin
                    new_cmd(i);
                    req[i] = 1'b1;
                end
            end
            hold_ack = N'($urandom);
            step();
        end
        hold_ack = '0;
        drain("random_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
